display_register_fetcher: RTL and testbench

- Frame-synchronous fetch controller that feeds the VGA display pipeline with game state.
- On each end-of-frame pulse it reads NUM_REGS consecutive processor registers through a shared, handshaked read port. These hold pipe x, gap centre, gap height, bird top edge and scores.
- The registers are collected in a staging buffer, then committed atomically to a shadow bank. The renderers therefore never see a half-updated frame.
- It also derives the game-underway flag from the committed snapshot.

---
 rtl/display_register_fetcher.sv | 148 ++++++++++++++
 tb/tb_display_register_fetcher.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_register_fetcher.sv
// display_register_fetcher: once per frame, reads a block of processor
// registers through a shared, handshaked read port. The registers are collected
// in a staging buffer and then committed in one cycle to a shadow bank. The
// renderers only ever see a complete snapshot.
module display_register_fetcher #(
  parameter int NUM_REGS   = 15,
  parameter int BASE_REG   = 10,
  parameter int ADDR_WIDTH = 5,
  parameter int TIMEOUT    = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       screen_end,
  output logic                       rd_req,
  output logic [ADDR_WIDTH-1:0]      rd_addr,
  input  logic                       rd_ack,
  input  logic [31:0]                rd_data,
  output logic [NUM_REGS*32-1:0]     shadow_regs,
  output logic                       frame_valid,
  output logic                       game_underway,
  output logic                       fetch_busy,
  output logic                       timeout_err,
  output logic                       overrun_err
);

  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REGS - 1);
  // The unacked edge that would bring the wait counter to TIMEOUT-1 aborts the fetch
  localparam logic [WAIT_W-1:0] ABORT_CNT = WAIT_W'(TIMEOUT - 2);

  // The fetched window must fit inside the register-file address space
  generate
    if (BASE_REG + NUM_REGS - 1 > (1 << ADDR_WIDTH) - 1) begin : g_addr_range_check
      $error("display_register_fetcher: BASE_REG+NUM_REGS-1 exceeds the address range");
    end
    if (TIMEOUT < 2) begin : g_timeout_check
      $error("display_register_fetcher: TIMEOUT must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    COMMIT
  } state_t;

  state_t              state, state_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic [WAIT_W-1:0]   wait_cnt, wait_n;
  logic                capture;
  logic                abort;
  logic                commit;
  logic [NUM_REGS*32-1:0] stage;

  // rd_addr is decoded straight from the register index
  assign rd_addr = ADDR_WIDTH'(BASE_REG) + ADDR_WIDTH'(idx);

  // State register with the register index and the per-register wait counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      wait_cnt <= wait_n;
    end
  end

  // Next-state logic and the decoded handshake/status outputs
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    wait_n     = wait_cnt;
    rd_req     = 1'b0;
    fetch_busy = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (screen_end) begin
          state_n = FETCH;
          idx_n   = '0;
          wait_n  = '0;
        end
      end
      FETCH: begin
        rd_req     = 1'b1;
        fetch_busy = 1'b1;
        if (rd_ack) begin
          capture = 1'b1;
          wait_n  = '0;
          if (idx == LAST_IDX) begin
            state_n = COMMIT;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else if (wait_cnt == ABORT_CNT) begin
          abort   = 1'b1;
          wait_n  = '0;
          state_n = IDLE;
        end else begin
          wait_n = wait_cnt + 1'b1;
        end
      end
      COMMIT: begin
        fetch_busy = 1'b1;
        commit     = 1'b1;
        state_n    = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Staging capture, atomic commit to the shadow bank, and the sticky error flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      stage         <= '0;
      shadow_regs   <= '0;
      frame_valid   <= 1'b0;
      game_underway <= 1'b0;
      timeout_err   <= 1'b0;
      overrun_err   <= 1'b0;
    end else begin
      frame_valid <= commit;
      if (capture) begin
        stage[32*idx +: 32] <= rd_data;
      end
      if (commit) begin
        shadow_regs   <= stage;
        game_underway <= |stage;
      end
      if (abort) begin
        timeout_err <= 1'b1;
      end
      if (screen_end && (state != IDLE)) begin
        overrun_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_register_fetcher.sv
// Testbench for display_register_fetcher: directed scenarios plus randomized
// traffic, compared every cycle against a transaction-level reference model.
module tb_display_register_fetcher;

  localparam int NUM_REGS   = 15;
  localparam int BASE_REG   = 10;
  localparam int ADDR_WIDTH = 5;
  localparam int TIMEOUT    = 64;
  localparam int SW         = NUM_REGS * 32;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   screen_end;
  logic                   rd_req;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic                   rd_ack;
  logic [31:0]            rd_data;
  logic [SW-1:0]          shadow_regs;
  logic                   frame_valid;
  logic                   game_underway;
  logic                   fetch_busy;
  logic                   timeout_err;
  logic                   overrun_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] reg_file [32];

  bit          m_fetching;
  bit          m_commit_next;
  bit          m_fv;
  bit          m_gu;
  bit          m_to;
  bit          m_ov;
  bit          m_addr_known;
  int          m_captured;
  int          m_waited;
  logic [31:0] m_snap   [NUM_REGS];
  logic [31:0] m_shadow [NUM_REGS];

  display_register_fetcher #(
    .NUM_REGS   (NUM_REGS),
    .BASE_REG   (BASE_REG),
    .ADDR_WIDTH (ADDR_WIDTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .screen_end    (screen_end),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_ack        (rd_ack),
    .rd_data       (rd_data),
    .shadow_regs   (shadow_regs),
    .frame_valid   (frame_valid),
    .game_underway (game_underway),
    .fetch_busy    (fetch_busy),
    .timeout_err   (timeout_err),
    .overrun_err   (overrun_err)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] packed_shadow();
    logic [SW-1:0] p;
    for (int i = 0; i < NUM_REGS; i++) p[32*i +: 32] = m_shadow[i];
    return p;
  endfunction

  // Reference model: advances one clock edge given the inputs seen at that edge
  task automatic model_step(input bit se, input bit ack, input bit rst_n);
    bit new_fv;
    new_fv = 1'b0;
    if (!rst_n) begin
      m_fetching = 0; m_commit_next = 0; m_gu = 0; m_to = 0; m_ov = 0;
      m_captured = 0; m_waited = 0; m_addr_known = 1;
      for (int i = 0; i < NUM_REGS; i++) m_shadow[i] = '0;
    end else if (m_commit_next) begin
      m_gu = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        m_shadow[i] = m_snap[i];
        if (m_snap[i] != 0) m_gu = 1'b1;
      end
      new_fv        = 1'b1;
      m_commit_next = 1'b0;
      if (se) m_ov = 1'b1;
    end else if (m_fetching) begin
      if (se) m_ov = 1'b1;
      if (ack) begin
        m_snap[m_captured] = reg_file[BASE_REG + m_captured];
        m_captured++;
        m_waited = 0;
        if (m_captured == NUM_REGS) begin
          m_fetching    = 1'b0;
          m_commit_next = 1'b1;
          m_addr_known  = 1'b0;
        end
      end else begin
        m_waited++;
        if (m_waited == TIMEOUT - 1) begin
          m_fetching   = 1'b0;
          m_to         = 1'b1;
          m_addr_known = 1'b0;
        end
      end
    end else if (se) begin
      m_fetching   = 1'b1;
      m_captured   = 0;
      m_waited     = 0;
      m_addr_known = 1'b1;
    end
    m_fv = new_fv;
  endtask

  // One clock cycle: check the current outputs, drive inputs, advance the model
  task automatic applyStimulus(input bit se, input bit ack, input bit rst_n);
    checkOutput("rd_req",        SW'(rd_req),        SW'(m_fetching));
    checkOutput("fetch_busy",    SW'(fetch_busy),    SW'(m_fetching | m_commit_next));
    checkOutput("frame_valid",   SW'(frame_valid),   SW'(m_fv));
    checkOutput("game_underway", SW'(game_underway), SW'(m_gu));
    checkOutput("timeout_err",   SW'(timeout_err),   SW'(m_to));
    checkOutput("overrun_err",   SW'(overrun_err),   SW'(m_ov));
    checkOutput("shadow_regs",   shadow_regs,        packed_shadow());
    if (m_addr_known) checkOutput("rd_addr", SW'(rd_addr), SW'(BASE_REG + m_captured));
    screen_end = se;
    rd_ack     = ack;
    reset      = rst_n;
    rd_data    = ack ? reg_file[rd_addr] : $urandom();
    @(posedge clk);
    model_step(se, ack, rst_n);
    @(negedge clk);
  endtask

  // Idle-line cycles; mode 1 acks every cycle, mode 3 every third, otherwise never
  task automatic run_cycles(input int n, input int mode);
    bit ack;
    for (int c = 0; c < n; c++) begin
      ack = (mode == 1) || ((mode == 3) && (c % 3 == 2));
      applyStimulus(1'b0, ack, 1'b1);
    end
  endtask

  task automatic fill_regs(input int mode);
    for (int a = 0; a < 32; a++) begin
      case (mode)
        0:       reg_file[a] = 32'h100 + 32'(a);
        1:       reg_file[a] = '0;
        default: reg_file[a] = $urandom();
      endcase
    end
  endtask

  initial begin
    screen_end = 1'b0;
    rd_ack     = 1'b0;
    rd_data    = '0;
    reset      = 1'b0;
    fill_regs(0);
    repeat (2) @(posedge clk);
    model_step(1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Reset state, then a zero-wait fetch of 0x100+addr
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    run_cycles(20, 1);

    // All-zero registers still pulse frame_valid but clear game_underway
    fill_regs(1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    run_cycles(20, 1);

    // Slow port acking every third cycle
    fill_regs(2);
    applyStimulus(1'b1, 1'b0, 1'b1);
    run_cycles(55, 3);

    // Timeout abort keeps the previous shadow, then a normal fetch
    applyStimulus(1'b1, 1'b0, 1'b1);
    run_cycles(70, 0);
    fill_regs(0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    run_cycles(20, 1);

    // Overrun in the middle of a fetch
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    run_cycles(5, 1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    run_cycles(20, 1);

    // Reset in the middle of a fetch, then a clean fetch from BASE_REG
    fill_regs(2);
    applyStimulus(1'b1, 1'b1, 1'b1);
    run_cycles(7, 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    run_cycles(3, 1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    run_cycles(20, 1);

    // screen_end on the commit edge is an overrun and starts nothing
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    run_cycles(15, 1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    run_cycles(5, 1);

    // screen_end together with the timeout abort sets both flags
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    run_cycles(62, 0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    run_cycles(5, 0);

    // Randomized traffic with occasional resets and register changes
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      if (c % 300 == 0) fill_regs(($urandom_range(0, 3) == 0) ? 1 : 2);
      applyStimulus($urandom_range(0, 39) == 0,
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 599) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
